// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch path.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0;

    // One buffered fetch: the returned instruction word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; head data is visible without a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count < CW'(DEPTH)) || w_do_pop);

    // Pointer and occupancy tracking; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!i_clear && w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, issues reads to a 1-cycle
// instruction memory and buffers returned words for decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = XLEN,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] flushPC,
    input  logic             stall,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             validF,
    output logic [WIDTH-1:0] instrF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned UW = CW + 1;

    logic [WIDTH-1:0] r_fpc;
    logic [WIDTH-1:0] r_inflight_pc;
    logic             r_inflight;

    logic [CW-1:0]    w_count;
    logic [UW-1:0]    w_used;
    logic             w_req;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_wr_entry;
    fetch_entry_t     w_head;

    // Credit counts buffered words plus the one in flight; a same-cycle pop is not credited.
    assign w_used  = UW'(w_count) + UW'(r_inflight);
    assign w_req   = !flush && (w_used < UW'(DEPTH));
    assign w_valid = (w_count != '0);
    assign w_push  = r_inflight && !flush;
    assign w_pop   = w_valid && !stall && !flush;

    assign mem_req  = w_req;
    assign mem_addr = r_fpc;

    assign w_wr_entry.instr = XLEN'(mem_rdata);
    assign w_wr_entry.pc    = XLEN'(r_inflight_pc);

    // Fetch PC and in-flight tracking; a redirect drops the outstanding read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (flush) begin
            r_fpc         <= flushPC;
            r_inflight    <= 1'b0;
        end else if (w_req) begin
            r_fpc         <= r_fpc + WIDTH'(4);
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fpc;
        end else begin
            r_inflight    <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_clear (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wr_entry),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // Present the FIFO head to decode, zeroed when nothing is buffered.
    always_comb begin
        validF   = w_valid;
        instrF   = '0;
        PCF      = '0;
        PCPlus4F = '0;
        if (w_valid) begin
            instrF   = WIDTH'(w_head.instr);
            PCF      = WIDTH'(w_head.pc);
            PCPlus4F = WIDTH'(w_head.pc) + WIDTH'(4);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: scoreboard of expected fetch PCs plus directed checks.
module tb_fetch_queue;

    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] RST_PC   = 32'h0;
    localparam logic [31:0] RST_PC_W = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_w;
    logic        flush;
    logic [31:0] flushPC;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        validF;
    logic [31:0] instrF, PCF, PCPlus4F;

    logic        mem_req_w;
    logic [31:0] mem_addr_w;
    logic [31:0] mem_rdata_w = '0;
    logic        validF_w;
    logic [31:0] instrF_w, PCF_w, PCPlus4F_w;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_next = RST_PC;

    always #5 clk = ~clk;

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(RST_PC)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .flushPC(flushPC), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .validF(validF), .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
    );

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(RST_PC_W)) u_dut_w (
        .clk(clk), .rst(rst_w), .flush(1'b0), .flushPC(32'h0), .stall(1'b0),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
        .validF(validF_w), .instrF(instrF_w), .PCF(PCF_w), .PCPlus4F(PCPlus4F_w)
    );

    // Synchronous instruction memories: data is the address xor a key.
    always @(posedge clk) if (mem_req)   mem_rdata   <= mem_addr ^ KEY;
    always @(posedge clk) if (mem_req_w) mem_rdata_w <= mem_addr_w ^ KEY;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: requests push expected PCs, decode handshakes pop them.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            exp_q.delete();
            exp_next = RST_PC;
            check("rst_validF", 32'(validF), 32'd0);
        end else if (flush) begin
            check("flush_mem_req", 32'(mem_req), 32'd0);
            exp_q.delete();
            exp_next = flushPC;
        end else begin
            if (mem_req) begin
                check("mem_addr", mem_addr, exp_next);
                exp_q.push_back(exp_next);
                exp_next = exp_next + 32'd4;
            end
            if (validF && !stall) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("PCF", PCF, e);
                    check("instrF", instrF, e ^ KEY);
                    check("PCPlus4F", PCPlus4F, e + 32'd4);
                end
            end
            if (!validF) begin
                check("idle_PCF", PCF, 32'd0);
                check("idle_instrF", instrF, 32'd0);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; rst_w = 1'b1; flush = 1'b0; flushPC = '0; stall = 1'b0;
        #1;
        rst = 1'b0; rst_w = 1'b0;
        #1;
        check("reset_validF", 32'(validF), 32'd0);
        check("reset_instrF", instrF, 32'd0);
        check("reset_PCF", PCF, 32'd0);
        check("reset_PCPlus4F", PCPlus4F, 32'd0);
        check("reset_mem_addr", mem_addr, RST_PC);

        // Free-running fetch after reset release
        @(negedge clk);
        step(); rst = 1'b1;
        @(negedge clk);
        check("c0_validF", 32'(validF), 32'd0);
        check("c0_mem_req", 32'(mem_req), 32'd1);
        check("c0_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        check("c1_validF", 32'(validF), 32'd0);
        @(negedge clk);
        check("c2_validF", 32'(validF), 32'd1);
        check("c2_PCF", PCF, 32'h0);
        repeat (10) @(negedge clk);

        // Stall from the start: exactly four requests, then hold
        step(); rst = 1'b0; stall = 1'b1;
        @(negedge clk);
        step(); rst = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req) n++;
        end
        check("stall_req_count", 32'(n), 32'd4);
        check("stall_validF", 32'(validF), 32'd1);
        check("stall_head_PCF", PCF, 32'h0);
        step(); stall = 1'b0;
        repeat (8) @(negedge clk);

        // Flush with three buffered and one in flight
        step(); rst = 1'b0; stall = 1'b1;
        @(negedge clk);
        step(); rst = 1'b1;
        repeat (4) step();
        check("full_credit_no_req", 32'(mem_req), 32'd0);
        check("pre_flush_validF", 32'(validF), 32'd1);
        flush = 1'b1; flushPC = 32'h40; stall = 1'b0;
        step(); flush = 1'b0;
        @(negedge clk);
        check("flush_t1_validF", 32'(validF), 32'd0);
        check("flush_t1_req", 32'(mem_req), 32'd1);
        check("flush_t1_addr", mem_addr, 32'h40);
        @(negedge clk);
        check("flush_t2_validF", 32'(validF), 32'd0);
        @(negedge clk);
        check("flush_t3_validF", 32'(validF), 32'd1);
        check("flush_t3_PCF", PCF, 32'h40);
        repeat (4) @(negedge clk);

        // Flush and stall together: flush wins
        step(); stall = 1'b1;
        step();
        step(); flush = 1'b1; flushPC = 32'h100;
        step(); flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("fs_validF", 32'(validF), 32'd0);
        check("fs_addr", mem_addr, 32'h100);
        @(negedge clk);
        @(negedge clk);
        check("fs_PCF", PCF, 32'h100);
        repeat (5) @(negedge clk);

        // Asynchronous reset between edges while full
        step(); stall = 1'b1;
        repeat (8) step();
        check("full_validF", 32'(validF), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_validF", 32'(validF), 32'd0);
        check("async_instrF", instrF, 32'd0);
        check("async_PCF", PCF, 32'd0);
        check("async_PCPlus4F", PCPlus4F, 32'd0);
        check("async_mem_addr", mem_addr, RST_PC);
        @(negedge clk);
        step(); rst = 1'b1; stall = 1'b0;
        @(negedge clk);
        check("rr_addr", mem_addr, RST_PC);
        check("rr_req", 32'(mem_req), 32'd1);
        repeat (2) @(negedge clk);
        check("rr_PCF", PCF, RST_PC);
        repeat (4) @(negedge clk);

        // PC wrap from a high reset vector
        step(); rst_w = 1'b1;
        @(negedge clk);
        check("w_c0_req", 32'(mem_req_w), 32'd1);
        check("w_c0_addr", mem_addr_w, 32'hFFFF_FFF8);
        @(negedge clk);
        check("w_c1_addr", mem_addr_w, 32'hFFFF_FFFC);
        @(negedge clk);
        check("w_c2_addr", mem_addr_w, 32'h0000_0000);
        check("w_c2_validF", 32'(validF_w), 32'd1);
        check("w_c2_PCF", PCF_w, 32'hFFFF_FFF8);
        check("w_c2_PCPlus4F", PCPlus4F_w, 32'hFFFF_FFFC);
        @(negedge clk);
        check("w_c3_PCF", PCF_w, 32'hFFFF_FFFC);
        check("w_c3_PCPlus4F", PCPlus4F_w, 32'h0000_0000);
        check("w_c3_instrF", instrF_w, 32'hFFFF_FFFC ^ KEY);
        @(negedge clk);
        check("w_c4_PCF", PCF_w, 32'h0000_0000);
        check("w_c4_PCPlus4F", PCPlus4F_w, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
